alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Execute->writeback boundary directly downstream of the ALU. Captures ALU
//  result/ccodes per accepted instruction, keeps the architectural nzpc
//  condition-code register and resolves conditional branches against it.
//  A 2-entry skid buffer decouples ALU issue from writeback back-pressure.
// PARAMETERS
//  DEPTH  2  skid-buffer entries (fixed at 2; any other value is unsupported)
// PORTS
//  i_clk       in   1   system clock, all state on rising edge
//  i_rst       in   1   asynchronous, active-high reset
//  i_valid     in   1   ALU output valid this cycle
//  o_ready     out  1   stage can accept (registered, = ~full)
//  i_result    in   16  ALU result
//  i_ccodes    in   4   ALU ccodes {n,z,p,c}
//  i_setCc     in   1   instruction updates CC register
//  i_wrEn      in   1   instruction writes register file
//  i_wrReg     in   3   destination register index
//  i_isBranch  in   1   instruction is conditional branch
//  i_brCond    in   4   branch mask {n,z,p,c}
//  i_brTarget  in   16  branch target address
//  i_flush     in   1   pipeline flush
//  o_valid     out  1   head entry valid
//  i_ready     in   1   writeback accepts head entry
//  o_result    out  16  head entry result
//  o_wrEn      out  1   head entry write enable (0 when ~o_valid)
//  o_wrReg     out  3   head entry destination
//  o_ccReg     out  4   current CC register {n,z,p,c}
//  o_brTaken   out  1   one-cycle pulse: branch resolved taken
//  o_brTarget  out  16  target, valid while o_brTaken
// BEHAVIOUR
//  - Reset: buffer empty, o_valid=0, o_ready=1, o_result=0, o_wrEn=0,
//    o_wrReg=0, o_ccReg=4'b0100 (z), o_brTaken=0, o_brTarget=0.
//  - accept = i_valid & o_ready & ~i_flush; pop = o_valid & i_ready.
//  - Every accepted instruction (incl. branches) enters buffer in order;
//    entry = {result, wrEn, wrReg}. count 0..2; o_ready=0 iff count==2.
//  - Latency: accepted at edge t -> visible on o_* after edge t (1 cycle).
//  - accept & pop same cycle: count unchanged, FIFO order kept; at count==2
//    no accept (o_ready=0) even if pop occurs that cycle.
//  - CC: on accept with i_setCc, o_ccReg <= i_ccodes at same edge.
//  - Branch: on accept with i_isBranch, taken = |(i_brCond[3:1] & o_ccReg[3:1])
//    using CC value before the edge; o_brTaken<=taken, o_brTarget<=i_brTarget
//    for exactly one cycle; else o_brTaken<=0. Mask 000 never taken.
//  - Branch and i_setCc together: branch uses old CC, CC then updates.
//  - i_flush: empties buffer (count<=0, o_valid<=0), drops input that cycle,
//    CC unchanged, o_brTaken<=0. Flush has priority over accept and pop.
//  - Reset mid-operation: immediate async return to reset values; pending
//    entries and branch pulse lost.
// CONFIGURATION
//  ALU_STAGE_CARRY_BR_EN defined: taken = |(i_brCond & o_ccReg) (carry usable).
//  Not defined: i_brCond[0] ignored; only n/z/p participate.
// TESTING
//  1 reset -> o_ready=1, o_valid=0, o_ccReg=4'b0100, o_brTaken=0.
//  2 i_valid, result 16'h1234, wrReg 3, i_ready=1 -> next cycle o_valid=1,
//    o_result=16'h1234, o_wrReg=3; cycle after o_valid=0.
//  3 i_ready=0, push 16'h0001,16'h0002 -> o_ready=0; 3rd push ignored;
//    i_ready=1 -> pops 0001 then 0002 in order, o_ready returns 1.
//  4 setCc ccodes 4'b1000, next branch mask 4'b1000 target 16'h00F0 ->
//    o_brTaken=1 one cycle, o_brTarget=16'h00F0; mask 4'b0010 -> no pulse.
//  5 ccodes 4'b0011 set, branch mask 4'b0001 -> taken only with
//    ALU_STAGE_CARRY_BR_EN; without it o_brTaken stays 0.
//  6 two buffered entries + i_valid + i_flush -> next cycle o_valid=0,
//    o_ready=1, o_ccReg unchanged; async i_rst mid-burst -> reset values.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU->writeback stage: 2-entry in-order skid buffer, nzpc CC register, branch resolve.
// Latency 1 cycle accept->o_*; o_ready drops when both entries are held, flush empties.
// ALU_STAGE_CARRY_BR_EN: carry bit of the branch mask participates in the taken test.
module alu_result_stage #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_result,
    input  logic [3:0]  i_ccodes,
    input  logic        i_setCc,
    input  logic        i_wrEn,
    input  logic [2:0]  i_wrReg,
    input  logic        i_isBranch,
    input  logic [3:0]  i_brCond,
    input  logic [15:0] i_brTarget,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_result,
    output logic        o_wrEn,
    output logic [2:0]  o_wrReg,
    output logic [3:0]  o_ccReg,
    output logic        o_brTaken,
    output logic [15:0] o_brTarget
);

    typedef struct packed {
        logic [15:0] result;
        logic        wrEn;
        logic [2:0]  wrReg;
    } entry_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    entry_t      headEnt;
    entry_t      tailEnt;
    entry_t      inEnt;
    logic [1:0]  count;
    logic [3:0]  ccReg;
    logic        brTaken;
    logic [15:0] brTarget;
    logic        accept;
    logic        pop;
    logic        brHit;

    assign inEnt   = '{result: i_result, wrEn: i_wrEn, wrReg: i_wrReg};
    assign o_ready = (count != FULL);
    assign o_valid = (count != 2'd0);
    assign accept  = i_valid & o_ready & ~i_flush;
    assign pop     = o_valid & i_ready;

`ifdef ALU_STAGE_CARRY_BR_EN
    assign brHit = |(i_brCond & ccReg);
`else
    assign brHit = |(i_brCond[3:1] & ccReg[3:1]);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count    <= 2'd0;
            headEnt  <= '0;
            tailEnt  <= '0;
            ccReg    <= 4'b0100;
            brTaken  <= 1'b0;
            brTarget <= 16'h0000;
        end else if (i_flush) begin
            count   <= 2'd0;
            brTaken <= 1'b0;
        end else begin
            // Simultaneous accept+pop only happens at count==1: new entry becomes head.
            if (accept && pop) begin
                headEnt <= inEnt;
            end else if (pop) begin
                headEnt <= tailEnt;
                count   <= count - 2'd1;
            end else if (accept) begin
                if (count == 2'd0) headEnt <= inEnt;
                else               tailEnt <= inEnt;
                count <= count + 2'd1;
            end
            brTaken <= accept & i_isBranch & brHit;
            if (accept && i_isBranch) brTarget <= i_brTarget;
            if (accept && i_setCc)    ccReg    <= i_ccodes;
        end
    end

    assign o_result   = o_valid ? headEnt.result : 16'h0000;
    assign o_wrEn     = o_valid & headEnt.wrEn;
    assign o_wrReg    = o_valid ? headEnt.wrReg : 3'd0;
    assign o_ccReg    = ccReg;
    assign o_brTaken  = brTaken;
    assign o_brTarget = brTarget;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus randomized run against a queue model.
module tb_alu_result_stage;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, o_ready, i_setCc, i_wrEn, i_isBranch, i_flush;
    logic        o_valid, i_ready, o_wrEn, o_brTaken;
    logic [15:0] i_result, i_brTarget, o_result, o_brTarget;
    logic [3:0]  i_ccodes, i_brCond, o_ccReg;
    logic [2:0]  i_wrReg, o_wrReg;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    alu_result_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_result(i_result), .i_ccodes(i_ccodes), .i_setCc(i_setCc), .i_wrEn(i_wrEn),
        .i_wrReg(i_wrReg), .i_isBranch(i_isBranch), .i_brCond(i_brCond),
        .i_brTarget(i_brTarget), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_wrEn(o_wrEn), .o_wrReg(o_wrReg), .o_ccReg(o_ccReg),
        .o_brTaken(o_brTaken), .o_brTarget(o_brTarget)
    );

`ifdef ALU_STAGE_CARRY_BR_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    task automatic idle();
        i_valid = 0; i_result = 0; i_ccodes = 0; i_setCc = 0; i_wrEn = 0; i_wrReg = 0;
        i_isBranch = 0; i_brCond = 0; i_brTarget = 0; i_flush = 0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] r, input logic [2:0] reg_idx);
        idle();
        i_valid = 1; i_result = r; i_wrEn = 1; i_wrReg = reg_idx;
    endtask

    task automatic do_reset();
        idle();
        i_ready = 1;
        i_rst = 1;
        tick();
        i_rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        checks++; if (o_ccReg !== 4'b0100) begin errors++; $display("FAIL reset_cc got %b exp 0100", o_ccReg); end
        checks++; if (o_brTaken !== 1'b0 || o_brTarget !== 16'h0) begin errors++; $display("FAIL reset_br got %b/%h exp 0/0000", o_brTaken, o_brTarget); end
        checks++; if (o_result !== 16'h0 || o_wrEn !== 1'b0 || o_wrReg !== 3'd0) begin errors++; $display("FAIL reset_head got %h/%b/%0d exp 0/0/0", o_result, o_wrEn, o_wrReg); end
    endtask

    task automatic test_single();
        i_ready = 1;
        push(16'h1234, 3'd3);
        tick();
        idle();
        checks++; if (o_valid !== 1'b1 || o_result !== 16'h1234 || o_wrReg !== 3'd3 || o_wrEn !== 1'b1) begin
            errors++; $display("FAIL single_out got v=%b r=%h reg=%0d we=%b exp 1/1234/3/1", o_valid, o_result, o_wrReg, o_wrEn); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_wrEn !== 1'b0) begin errors++; $display("FAIL single_drain got v=%b we=%b exp 0/0", o_valid, o_wrEn); end
    endtask

    task automatic test_backpressure();
        i_ready = 0;
        push(16'h0001, 3'd1); tick();
        push(16'h0002, 3'd2); tick();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", o_ready); end
        push(16'h0003, 3'd3); tick();
        idle();
        checks++; if (o_ready !== 1'b0 || o_result !== 16'h0001) begin errors++; $display("FAIL bp_hold got rdy=%b r=%h exp 0/0001", o_ready, o_result); end
        i_ready = 1; tick();
        checks++; if (o_valid !== 1'b1 || o_result !== 16'h0002 || o_ready !== 1'b1) begin
            errors++; $display("FAIL bp_pop1 got v=%b r=%h rdy=%b exp 1/0002/1", o_valid, o_result, o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0 (third push leaked)", o_valid); end
    endtask

    task automatic test_branch();
        i_ready = 1;
        idle(); i_valid = 1; i_setCc = 1; i_ccodes = 4'b1000; tick();
        checks++; if (o_ccReg !== 4'b1000) begin errors++; $display("FAIL br_setcc got %b exp 1000", o_ccReg); end
        idle(); i_valid = 1; i_isBranch = 1; i_brCond = 4'b1000; i_brTarget = 16'h00F0; tick();
        idle();
        checks++; if (o_brTaken !== 1'b1 || o_brTarget !== 16'h00F0) begin errors++; $display("FAIL br_taken got %b/%h exp 1/00F0", o_brTaken, o_brTarget); end
        tick();
        checks++; if (o_brTaken !== 1'b0) begin errors++; $display("FAIL br_pulse got %b exp 0", o_brTaken); end
        idle(); i_valid = 1; i_isBranch = 1; i_brCond = 4'b0010; i_brTarget = 16'h0055; tick();
        checks++; if (o_brTaken !== 1'b0) begin errors++; $display("FAIL br_nottaken got %b exp 0", o_brTaken); end
        // branch with setCc: old CC (n) decides, CC then becomes p
        idle(); i_valid = 1; i_isBranch = 1; i_brCond = 4'b1000; i_brTarget = 16'hBEEF;
        i_setCc = 1; i_ccodes = 4'b0010; tick();
        idle();
        checks++; if (o_brTaken !== 1'b1 || o_ccReg !== 4'b0010) begin errors++; $display("FAIL br_oldcc got %b/%b exp 1/0010", o_brTaken, o_ccReg); end
        tick();
    endtask

    task automatic test_carry();
        i_ready = 1;
        idle(); i_valid = 1; i_setCc = 1; i_ccodes = 4'b0011; tick();
        idle(); i_valid = 1; i_isBranch = 1; i_brCond = 4'b0001; i_brTarget = 16'h0C0C; tick();
        idle();
        checks++; if (o_brTaken !== CARRY_EN) begin errors++; $display("FAIL carry_br got %b exp %b", o_brTaken, CARRY_EN); end
        tick();
    endtask

    task automatic test_flush();
        logic [3:0] ccBefore;
        i_ready = 0;
        push(16'hAAAA, 3'd4); tick();
        push(16'hBBBB, 3'd5); tick();
        ccBefore = o_ccReg;
        push(16'hCCCC, 3'd6);
        i_flush = 1; i_setCc = 1; i_ccodes = ~ccBefore; i_isBranch = 1; i_brCond = 4'b1111;
        tick();
        idle();
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got v=%b rdy=%b exp 0/1", o_valid, o_ready); end
        checks++; if (o_ccReg !== ccBefore || o_brTaken !== 1'b0) begin errors++; $display("FAIL flush_cc got %b/%b exp %b/0", o_ccReg, o_brTaken, ccBefore); end
        i_ready = 1;
    endtask

    task automatic test_async_reset();
        i_ready = 0;
        idle(); i_valid = 1; i_setCc = 1; i_ccodes = 4'b1000; tick();
        idle(); i_valid = 1; i_isBranch = 1; i_brCond = 4'b1110; i_brTarget = 16'h7777; tick();
        idle();
        #2 i_rst = 1;
        #1;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_ccReg !== 4'b0100 || o_brTaken !== 1'b0 || o_brTarget !== 16'h0) begin
            errors++; $display("FAIL async_rst got v=%b rdy=%b cc=%b bt=%b tgt=%h exp 0/1/0100/0/0000", o_valid, o_ready, o_ccReg, o_brTaken, o_brTarget); end
        @(negedge i_clk);
        i_rst = 0;
        i_ready = 1;
    endtask

    typedef struct packed { logic [15:0] result; logic wrEn; logic [2:0] wrReg; } ent_t;

    task automatic test_random();
        ent_t        q[$];
        logic [3:0]  cc = 4'b0100;
        logic        expBr = 0;
        logic [15:0] expTgt = 0;
        bit          canAccept, doAccept, doPop, taken;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            i_valid    = ($urandom_range(0, 9) < 7);
            i_result   = 16'($urandom);
            i_ccodes   = 4'($urandom);
            i_setCc    = ($urandom_range(0, 2) == 0);
            i_wrEn     = 1'($urandom);
            i_wrReg    = 3'($urandom);
            i_isBranch = ($urandom_range(0, 2) == 0);
            i_brCond   = 4'($urandom);
            i_brTarget = 16'($urandom);
            i_flush    = ($urandom_range(0, 15) == 0);
            i_ready    = ($urandom_range(0, 9) < 6);

            canAccept = (q.size() < 2);
            doAccept  = i_valid && canAccept && !i_flush;
            doPop     = (q.size() > 0) && i_ready;
            taken = 0;
            for (int b = 3; b >= 0; b--)
                if ((b > 0 || CARRY_EN) && i_brCond[b] && cc[b]) taken = 1;
            if (i_flush) begin
                q.delete();
                expBr = 0;
            end else begin
                if (doPop) void'(q.pop_front());
                if (doAccept) q.push_back('{result: i_result, wrEn: i_wrEn, wrReg: i_wrReg});
                expBr = doAccept && i_isBranch && taken;
                if (doAccept && i_isBranch) expTgt = i_brTarget;
                if (doAccept && i_setCc) cc = i_ccodes;
            end
            tick();

            checks++; if (o_valid !== (q.size() > 0) || o_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rnd_flow cyc=%0d got v=%b rdy=%b exp v=%b rdy=%b", cyc, o_valid, o_ready, q.size() > 0, q.size() < 2); end
            if (q.size() > 0) begin
                checks++; if (o_result !== q[0].result || o_wrEn !== q[0].wrEn || o_wrReg !== q[0].wrReg) begin
                    errors++; $display("FAIL rnd_head cyc=%0d got %h/%b/%0d exp %h/%b/%0d", cyc, o_result, o_wrEn, o_wrReg, q[0].result, q[0].wrEn, q[0].wrReg); end
            end else begin
                checks++; if (o_wrEn !== 1'b0) begin errors++; $display("FAIL rnd_wren cyc=%0d got %b exp 0", cyc, o_wrEn); end
            end
            checks++; if (o_ccReg !== cc) begin errors++; $display("FAIL rnd_cc cyc=%0d got %b exp %b", cyc, o_ccReg, cc); end
            checks++; if (o_brTaken !== expBr) begin errors++; $display("FAIL rnd_br cyc=%0d got %b exp %b", cyc, o_brTaken, expBr); end
            if (expBr) begin
                checks++; if (o_brTarget !== expTgt) begin errors++; $display("FAIL rnd_tgt cyc=%0d got %h exp %h", cyc, o_brTarget, expTgt); end
            end
        end
        idle();
    endtask

    initial begin
        i_rst = 1;
        i_ready = 1;
        idle();
        test_reset();
        test_single();
        test_backpressure();
        test_branch();
        test_carry();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
